// File: rtl/fetch_sequencer.sv
// Instruction-fetch / decode sequencer: fetches one word per instruction, pulses the
// decoder enable once, holds the result until execute accepts it, handles redirects and faults.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  output logic        O_bus_req,
  output logic [31:0] O_bus_addr,
  input  logic        I_bus_ack,
  input  logic [31:0] I_bus_data,
  output logic [31:0] O_instr,
  output logic        O_dec_en,
  output logic        O_valid,
  output logic [31:0] O_pc,
  input  logic        I_ready,
  input  logic        I_redirect,
  input  logic [31:0] I_redirect_pc,
  output logic        O_fault,
  output logic [1:0]  O_fault_cause
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned CAUSE_W = 2;

  localparam logic [WAIT_W-1:0]  TO_LAST = (TIMEOUT == 0) ? WAIT_W'(0) : WAIT_W'(TIMEOUT - 1);
  localparam logic               TO_EN   = (TIMEOUT != 0);

  localparam logic [CAUSE_W-1:0] CAUSE_NONE     = 2'b00;
  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_VALID  = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [XLEN-1:0]     r_pc;
  logic [XLEN-1:0]     r_instr;
  logic [XLEN-1:0]     r_dec_pc;
  logic [CAUSE_W-1:0]  r_cause;
  logic [WAIT_W-1:0]   r_wait;

  logic [XLEN-1:0]     w_pc_nxt;
  logic [XLEN-1:0]     w_instr_nxt;
  logic [XLEN-1:0]     w_dec_pc_nxt;
  logic [CAUSE_W-1:0]  w_cause_nxt;
  logic [WAIT_W-1:0]   w_wait_nxt;

  logic                w_redir_take;
  logic                w_redir_aligned;

  // Redirect is ignored only in IDLE, the single cycle after reset release.
  assign w_redir_take    = I_redirect && (r_state != ST_IDLE);
  assign w_redir_aligned = (I_redirect_pc[1:0] == 2'b00);

  // State register.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers, updated from the next-state logic below.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_dec_pc <= '0;
      r_cause  <= CAUSE_NONE;
      r_wait   <= '0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_instr  <= w_instr_nxt;
      r_dec_pc <= w_dec_pc_nxt;
      r_cause  <= w_cause_nxt;
      r_wait   <= w_wait_nxt;
    end
  end

  // Next-state and datapath update logic; redirect has top priority.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_instr_nxt  = r_instr;
    w_dec_pc_nxt = r_dec_pc;
    w_cause_nxt  = r_cause;
    w_wait_nxt   = r_wait;

    if (w_redir_take) begin
      if (w_redir_aligned) begin
        w_state_nxt = ST_FETCH;
        w_pc_nxt    = I_redirect_pc;
        w_wait_nxt  = '0;
        w_cause_nxt = CAUSE_NONE;
      end else begin
        w_state_nxt = ST_FAULT;
        w_cause_nxt = CAUSE_MISALIGN;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_FETCH;
        end
        ST_FETCH: begin
          if (I_bus_ack) begin
            w_instr_nxt = I_bus_data;
            w_wait_nxt  = '0;
            w_state_nxt = ST_DECODE;
          end else if (TO_EN && (r_wait == TO_LAST)) begin
            w_state_nxt = ST_FAULT;
            w_cause_nxt = CAUSE_TIMEOUT;
          end else begin
            w_wait_nxt = r_wait + WAIT_W'(1);
          end
        end
        ST_DECODE: begin
          w_dec_pc_nxt = r_pc;
          w_pc_nxt     = r_pc + XLEN'(4);
          w_state_nxt  = ST_VALID;
        end
        ST_VALID: begin
          if (I_ready) begin
            w_state_nxt = ST_FETCH;
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode; req and dec_en are squashed in the redirect cycle.
  always_comb begin
    O_bus_req     = (r_state == ST_FETCH) && !I_redirect;
    O_dec_en      = (r_state == ST_DECODE) && !I_redirect;
    O_valid       = (r_state == ST_VALID);
    O_fault       = (r_state == ST_FAULT);
    O_fault_cause = r_cause;
    O_bus_addr    = r_pc;
    O_instr       = r_instr;
    O_pc          = r_dec_pc;
  end

endmodule
